// File: rtl/siso_trellis_ctrl.sv
// Max-log-MAP SISO trellis sequencer: forward/backward recursion control.
// Optional abort port pair enabled by SISO_TRELLIS_CTRL_ABORT_EN.
module siso_trellis_ctrl #(
  parameter int LEN_W  = 13,
  parameter int MAX_K  = 6144,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SISO_TRELLIS_CTRL_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  input  logic             start,
  input  logic [LEN_W-1:0] blk_len,
  input  logic             bm_avail,
  output logic             busy,
  output logic             done,
  output logic [1:0]       fsm_state,
  output logic             valid_branch,
  output logic             bm_rd_en,
  output logic [LEN_W-1:0] bm_rd_addr,
  output logic             am_wr_en,
  output logic [LEN_W-1:0] am_wr_addr,
  output logic             am_rd_en,
  output logic [LEN_W-1:0] am_rd_addr,
  output logic             llr_valid,
  output logic [LEN_W-1:0] llr_addr
);

  localparam int P    = RD_LAT + 2;
  localparam int PH_W = 3;
  localparam logic [LEN_W-1:0] KMAX = LEN_W'(MAX_K);
  localparam logic [PH_W-1:0]  PH_VB = PH_W'(RD_LAT);
  localparam logic [PH_W-1:0]  PH_LST = PH_W'(P - 1);
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_FWD  = 2'b01,
    S_BWD  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] k_q, k_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] bidx_q, bidx_d;
  logic [LEN_W-1:0] saddr_q, saddr_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic             pend_q, pend_d;
`ifdef SISO_TRELLIS_CTRL_ABORT_EN
  logic             abrt_q, abrt_d;
`endif

  logic             act;
  logic             slot;
  logic             more;
  logic             issue;
  logic             fire;
  logic             is_fwd;
  logic             is_bwd;
  logic [LEN_W-1:0] k_in;
  logic [LEN_W-1:0] rd_addr;

  assign is_fwd  = (state_q == S_FWD);
  assign is_bwd  = (state_q == S_BWD);
  assign act     = is_fwd | is_bwd;
  assign slot    = act & (ph_q == '0);
  assign more    = (cnt_q != k_q);
  assign issue   = slot & more & bm_avail;
  // a completed step's write/strobe lands on the next issue slot
  assign fire    = slot & pend_q;
  assign k_in    = (blk_len > KMAX) ? KMAX : blk_len;
  assign rd_addr = is_fwd ? cnt_q : bidx_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
    saddr_d = saddr_q;
    ph_d    = ph_q;
    pend_d  = pend_q;
`ifdef SISO_TRELLIS_CTRL_ABORT_EN
    abrt_d  = 1'b0;
`endif
    unique case (1'b1)
      state_q == S_IDLE: begin
        if (start) begin
          k_d     = k_in;
          cnt_d   = '0;
          ph_d    = '0;
          pend_d  = 1'b0;
          state_d = (k_in == '0) ? S_DONE : S_FWD;
        end
      end
      act: begin
        if (ph_q != '0) begin
          ph_d = (ph_q == PH_LST) ? '0 : ph_q + 1'b1;
          if (ph_q == PH_LST) pend_d = 1'b1;
        end else begin
          if (fire) pend_d = 1'b0;
          if (issue) begin
            ph_d    = 3'd1;
            cnt_d   = cnt_q + ONE;
            saddr_d = rd_addr;
            if (is_bwd && bidx_q != '0)
              bidx_d = bidx_q - ONE;
          end else if (!more) begin
            cnt_d = '0;
            if (is_fwd) begin
              state_d = S_BWD;
              bidx_d  = k_q - ONE;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      state_q == S_DONE: begin
        state_d = S_IDLE;
      end
      default: ;
    endcase
`ifdef SISO_TRELLIS_CTRL_ABORT_EN
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      ph_d    = '0;
      pend_d  = 1'b0;
      abrt_d  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      bidx_q  <= '0;
      saddr_q <= '0;
      ph_q    <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      saddr_q <= saddr_d;
      ph_q    <= ph_d;
      pend_q  <= pend_d;
    end
  end

`ifdef SISO_TRELLIS_CTRL_ABORT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) abrt_q <= 1'b0;
    else        abrt_q <= abrt_d;
  end
  assign aborted = abrt_q;
`endif

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign fsm_state    = state_q;
  assign valid_branch = act & (ph_q == PH_VB);
  assign bm_rd_en     = issue;
  assign bm_rd_addr   = issue ? rd_addr : '0;
  assign am_rd_en     = issue & is_bwd;
  assign am_rd_addr   = am_rd_en ? bidx_q : '0;
  assign am_wr_en     = fire & is_fwd;
  assign am_wr_addr   = am_wr_en ? saddr_q : '0;
  assign llr_valid    = fire & is_bwd;
  assign llr_addr     = llr_valid ? saddr_q : '0;

endmodule

// File: tb/tb_siso_trellis_ctrl.sv
// Scoreboard bench for siso_trellis_ctrl against a step-timing model.
// Abort checks compile in with SISO_TRELLIS_CTRL_ABORT_EN.
module tb_siso_trellis_ctrl;
  localparam int LEN_W  = 13;
  localparam int MAX_K  = 6144;
  localparam int RD_LAT = 1;
  localparam int P      = RD_LAT + 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] blk_len;
  logic             bm_avail;
  logic             busy, done, valid_branch;
  logic [1:0]       fsm_state;
  logic             bm_rd_en, am_wr_en, am_rd_en, llr_valid;
  logic [LEN_W-1:0] bm_rd_addr, am_wr_addr, am_rd_addr, llr_addr;
`ifdef SISO_TRELLIS_CTRL_ABORT_EN
  logic             abort;
  logic             aborted;
`endif

  siso_trellis_ctrl #(
    .LEN_W(LEN_W), .MAX_K(MAX_K), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef SISO_TRELLIS_CTRL_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .start(start), .blk_len(blk_len), .bm_avail(bm_avail),
    .busy(busy), .done(done), .fsm_state(fsm_state),
    .valid_branch(valid_branch),
    .bm_rd_en(bm_rd_en), .bm_rd_addr(bm_rd_addr),
    .am_wr_en(am_wr_en), .am_wr_addr(am_wr_addr),
    .am_rd_en(am_rd_en), .am_rd_addr(am_rd_addr),
    .llr_valid(llr_valid), .llr_addr(llr_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int addr;
    int st;
  } ev_t;

  ev_t bmq[$];
  ev_t amrq[$];
  ev_t wrq[$];
  ev_t llrq[$];
  int  vbq[$];
  int  done_exp;
  int  cyc = 0;
  int  t0 = 0;
  bit  trk = 0;
  bit  got_done;
  bit  use_av = 0;
  bit  avail[1024];
  int  vec = 0;
  int  err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit av(int t);
    if (!use_av || t < 0 || t >= 1024) return 1'b1;
    return avail[t];
  endfunction

  task automatic chk(string nm, int act, int exp);
    vec++;
    if (act != exp) begin
      err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Event timeline from the step rules: issue waits for bm_avail,
  // compute RD_LAT later, write/strobe one period after issue.
  task automatic build(int k);
    int t;
    bmq.delete(); amrq.delete(); wrq.delete();
    llrq.delete(); vbq.delete();
    t = 1;
    for (int i = 0; i < k; i++) begin
      while (!av(t)) t++;
      bmq.push_back('{t, i, 1});
      vbq.push_back(t + RD_LAT);
      wrq.push_back('{t + P, i, 1});
      t += P;
    end
    if (k > 0) t++;
    for (int j = 0; j < k; j++) begin
      int n = k - 1 - j;
      while (!av(t)) t++;
      bmq.push_back('{t, n, 2});
      amrq.push_back('{t, n, 2});
      vbq.push_back(t + RD_LAT);
      llrq.push_back('{t + P, n, 2});
      t += P;
    end
    done_exp = (k == 0) ? 1 : t + 1;
  endtask

  always @(posedge clk) begin
    #1;
    bm_avail = trk ? av(cyc - t0 + 1) : 1'b1;
  end

  always @(negedge clk) begin
    int  rel;
    ev_t e;
    int  v;
    if (trk && rst_n) begin
      rel = cyc - t0 + 1;
      if (bm_rd_en) begin
        if (bmq.size() == 0) chk("bm_extra", rel, -1);
        else begin
          e = bmq.pop_front();
          chk("bm_cyc", rel, e.cyc);
          chk("bm_addr", int'(bm_rd_addr), e.addr);
          chk("bm_state", int'(fsm_state), e.st);
        end
      end
      if (am_rd_en) begin
        if (amrq.size() == 0) chk("amrd_extra", rel, -1);
        else begin
          e = amrq.pop_front();
          chk("amrd_cyc", rel, e.cyc);
          chk("amrd_addr", int'(am_rd_addr), e.addr);
        end
      end
      if (am_wr_en) begin
        if (wrq.size() == 0) chk("amwr_extra", rel, -1);
        else begin
          e = wrq.pop_front();
          chk("amwr_cyc", rel, e.cyc);
          chk("amwr_addr", int'(am_wr_addr), e.addr);
          chk("amwr_state", int'(fsm_state), e.st);
        end
      end
      if (llr_valid) begin
        if (llrq.size() == 0) chk("llr_extra", rel, -1);
        else begin
          e = llrq.pop_front();
          chk("llr_cyc", rel, e.cyc);
          chk("llr_addr", int'(llr_addr), e.addr);
          chk("llr_state", int'(fsm_state), e.st);
        end
      end
      if (valid_branch) begin
        if (vbq.size() == 0) chk("vb_extra", rel, -1);
        else begin
          v = vbq.pop_front();
          chk("vb_cyc", rel, v);
        end
      end
      if (done) begin
        chk("done_cyc", rel, done_exp);
        chk("done_busy", int'(busy), 1);
        chk("done_state", int'(fsm_state), 3);
        got_done = 1'b1;
      end
    end
  end

  task automatic launch(int len);
    int k = (len > MAX_K) ? MAX_K : len;
    build(k);
    @(negedge clk);
    t0       = cyc + 1;
    got_done = 1'b0;
    trk      = 1'b1;
    blk_len  = LEN_W'(len);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic run_block(int len, bit poke);
    launch(len);
    if (poke && len > 0) begin
      @(negedge clk);
      start   = 1'b1;
      blk_len = LEN_W'(3);
      @(negedge clk);
      start   = 1'b0;
    end
    for (int c = 0; c < done_exp + 20 && !got_done; c++)
      @(negedge clk);
    if (!got_done) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_state", int'(fsm_state), 0);
    chk("leftover", bmq.size() + amrq.size() + wrq.size()
        + llrq.size() + vbq.size(), 0);
    trk    = 1'b0;
    use_av = 1'b0;
  endtask

  task automatic chk_quiet(string nm);
    chk(nm, int'({busy, done, fsm_state, valid_branch, bm_rd_en,
                  am_wr_en, am_rd_en, llr_valid}), 0);
    chk({nm, "_addr"}, int'(bm_rd_addr | am_wr_addr
                            | am_rd_addr | llr_addr), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    blk_len  = '0;
    bm_avail = 1'b1;
`ifdef SISO_TRELLIS_CTRL_ABORT_EN
    abort    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst_n = 1'b1;

    run_block(4, 1'b1);
    run_block(0, 1'b0);

    for (int i = 0; i < 1024; i++) avail[i] = 1'b1;
    for (int i = 4; i < 9; i++) avail[i] = 1'b0;
    use_av = 1'b1;
    run_block(3, 1'b0);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 1024; i++)
        avail[i] = ($urandom_range(0, 3) != 0);
      use_av = 1'b1;
      run_block(int'($urandom_range(0, 12)), bit'($urandom_range(0, 1)));
    end

    run_block(8000, 1'b0);

    launch(4);
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    trk = 1'b0;
    #1 chk_quiet("midblk_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_block(2, 1'b0);

`ifdef SISO_TRELLIS_CTRL_ABORT_EN
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", int'(busy), 0);
    chk("idle_abort_flag", int'(aborted), 0);
    launch(6);
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    trk   = 1'b0;
    abort = 1'b0;
    chk("abort_flag", int'(aborted), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_state", int'(fsm_state), 0);
    chk("abort_done", int'(done), 0);
    chk_quiet("abort_strobes");
    @(negedge clk);
    chk("abort_pulse", int'(aborted), 0);
    chk("abort_nodone", int'(done), 0);
    run_block(2, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/siso_trellis_ctrl.md
Name: siso_trellis_ctrl

Overview:
- Sequencer for the max-log-MAP SISO trellis datapath. It drives the forward (alpha) and backward (beta) state-metric recursion units through one code block.
- Generates the shared `fsm_state` and `valid_branch` controls, branch-metric memory reads, alpha-memory writes and reads, and LLR-output strobes.
- Sits between the block-level start/done handshake and the alpha/beta/LLR datapath.

Parameters:
- LEN_W, 13: width of block length and all address buses.
- MAX_K, 6144: maximum block length; `blk_len` above this is clamped to MAX_K.
- RD_LAT, 1: branch-metric memory read latency in cycles, legal range 1..4.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  block start request; sampled only while busy=0.
- blk_len  in  LEN_W  block length K; sampled with an accepted start.
- bm_avail  in  1  branch metrics for the next step are readable; when 0, read issue stalls.
- busy  out  1  block in progress.
- done  out  1  one-cycle pulse at block completion.
- fsm_state  out  2  datapath mode: 00 IDLE (recursion registers held at init), 01 FWD, 10 BWD, 11 DONE.
- valid_branch  out  1  compute strobe to the recursion units.
- bm_rd_en  out  1  branch-metric read enable.
- bm_rd_addr  out  LEN_W  branch-metric read address.
- am_wr_en  out  1  alpha-memory write enable.
- am_wr_addr  out  LEN_W  alpha-memory write address.
- am_rd_en  out  1  alpha-memory read enable (BWD only).
- am_rd_addr  out  LEN_W  alpha-memory read address.
- llr_valid  out  1  LLR/beta result strobe.
- llr_addr  out  LEN_W  trellis index of the LLR result.

Behaviour:
- Reset: all outputs 0, fsm_state=00, FSM in IDLE, counters 0. Reset is asynchronous and may occur mid-block; the block is abandoned and no done pulse is issued.
- Step period P = RD_LAT+2. A step issued (read) at cycle t produces:
  - valid_branch=1 at t+RD_LAT (compute phase);
  - valid_branch=0 at t+RD_LAT+1 (datapath register/saturate phase);
  - write/strobe at t+P, which coincides with the next step's read issue.
- Start: start=1 with busy=0 is sampled at edge e0. K = min(blk_len, MAX_K), latched. busy=1 from cycle 1. start while busy=1 is ignored.
- K=0: no FWD/BWD phases. DONE state at cycle 1 (fsm_state=11, done=1, busy=1), then IDLE.
- FWD (fsm_state=01):
  - step i=0..K-1: bm_rd_en=1, bm_rd_addr=i at issue;
  - am_wr_en=1, am_wr_addr=i one period later;
  - after the last write, one drain cycle, then BWD.
- BWD (fsm_state=10):
  - step j=0..K-1 with index n=K-1-j: bm_rd_en=am_rd_en=1, both addresses=n at issue;
  - llr_valid=1, llr_addr=n one period later;
  - after the last strobe, go to DONE.
- DONE (fsm_state=11): lasts 1 cycle with done=1; busy drops on the following cycle and the FSM returns to IDLE.
- Stall:
  - A read issues only if bm_avail=1 in the issue cycle. Otherwise the issue cycle repeats; steps already in flight complete normally, and no new valid_branch is generated.
  - A write/strobe coincident with a stalled issue still fires exactly once.
- Stall-free timing: FWD read i at cycle 1+iP; BWD read j at 2+KP+jP; done at 3+2KP.
- fsm_state changes only in cycles where valid_branch=0 and no step is in flight.
- valid_branch is never high for two consecutive cycles.
- Counters are LEN_W wide. The BWD index counts down from K-1 and stops at 0 with no wrap.

Optional Feature:
- Macro SISO_TRELLIS_CTRL_ABORT_EN adds input `abort` (1 bit) and output `aborted` (1 bit).
- With the macro defined, abort=1 in any non-IDLE state:
  - on the next edge, all strobes go to 0, fsm_state=00, busy=0, and aborted pulses for 1 cycle;
  - done is not pulsed;
  - abort in IDLE has no effect;
  - abort takes priority over every state transition in the same cycle.
- Without the macro, the ports are absent and behaviour is as above.

Test Plan:
- K=4, RD_LAT=1, bm_avail=1 → FWD reads at cycles 1,4,7,10 (addr 0..3); am writes at cycles 4,7,10,13; BWD reads at 14,17,20,23 (addr 3,2,1,0); llr_valid at 17,20,23,26; done at cycle 27; busy low at cycle 28.
- K=0 → done at cycle 1, no bm_rd_en/valid_branch/am_wr_en ever, fsm_state 11 for one cycle only.
- K=3, bm_avail=0 for 5 cycles at FWD step 1 issue → that read delays by 5; am write for step 0 still once at cycle 4; done at 3+18+5=26.
- blk_len=8000 → K clamped to 6144; last FWD write addr 6143; first BWD read addr 6143.
- rst_n low mid-BWD, then start with K=2 → all outputs 0 immediately; new block runs with stall-free timing, done at 3+2·2·3=15.
- ABORT_EN: abort during FWD step 2 → next cycle fsm_state=00, busy=0, aborted=1, done never asserted; next start accepted.
